// File: rtl/egress_tx_framer.sv
// Egress MAC framer: wraps a byte stream as an Ethernet frame on a GMII-style
// byte interface (preamble/SFD, zero pad, CRC32 FCS, inter-frame gap, underrun abort).
module egress_tx_framer #(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_FRAME      = 60,
  parameter bit          PAD_EN         = 1'b1,
  parameter int unsigned IFG_BYTES      = 12,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic [7:0]       gmii_txd,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_underruns,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
  } state_t;

  localparam logic [15:0] PRE_N = 16'(PREAMBLE_BYTES);
  localparam logic [15:0] IFG_N = 16'(IFG_BYTES);
  localparam logic [11:0] MIN_N = 12'(MIN_FRAME);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [10:0] byte_cnt, byte_cnt_nx, byte_cnt_inc;
  logic [11:0] byte_cnt_p1;
  logic [31:0] crc, crc_nx, crc_fcs;
  logic [7:0]  txd_nx;
  logic        tx_en_nx, tx_er_nx;
  logic        frame_inc, underrun_inc;

  // Reflected IEEE 802.3 CRC32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign byte_cnt_p1  = {1'b0, byte_cnt} + 12'd1;
  assign crc_fcs      = ~crc;
  assign in_ready     = (state == S_DATA) || (state == S_DROP);
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    byte_cnt_nx  = byte_cnt;
    crc_nx       = crc;
    txd_nx       = 8'h00;
    tx_en_nx     = 1'b0;
    tx_er_nx     = 1'b0;
    frame_inc    = 1'b0;
    underrun_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nx = S_PRE;
          txd_nx   = 8'h55;
          tx_en_nx = 1'b1;
          cnt_nx   = 16'd1;
        end
      end
      S_PRE: begin
        tx_en_nx = 1'b1;
        if (cnt < PRE_N) begin
          txd_nx = 8'h55;
          cnt_nx = cnt + 16'd1;
        end else begin
          txd_nx      = 8'hD5;
          state_nx    = S_DATA;
          crc_nx      = '1;
          byte_cnt_nx = '0;
        end
      end
      S_DATA: begin
        tx_en_nx = 1'b1;
        if (in_valid) begin
          txd_nx      = in_data;
          crc_nx      = crc32_byte(crc, in_data);
          byte_cnt_nx = byte_cnt_inc;
          if (in_last) begin
            cnt_nx   = '0;
            state_nx = (PAD_EN && (byte_cnt_p1 < MIN_N)) ? S_PAD : S_FCS;
          end
        end else begin
          // Underrun: one marked byte on the wire, then silently drain the packet.
          tx_er_nx     = 1'b1;
          underrun_inc = 1'b1;
          state_nx     = S_DROP;
        end
      end
      S_PAD: begin
        tx_en_nx    = 1'b1;
        crc_nx      = crc32_byte(crc, 8'h00);
        byte_cnt_nx = byte_cnt_inc;
        if (byte_cnt_p1 >= MIN_N) begin
          cnt_nx   = '0;
          state_nx = S_FCS;
        end
      end
      S_FCS: begin
        tx_en_nx = 1'b1;
        txd_nx   = crc_fcs[{cnt[1:0], 3'b000} +: 8];
        cnt_nx   = cnt + 16'd1;
        if (cnt[1:0] == 2'd3) begin
          frame_inc = 1'b1;
          cnt_nx    = '0;
          state_nx  = S_IFG;
        end
      end
      S_DROP: begin
        if (in_valid && in_last) begin
          cnt_nx   = '0;
          state_nx = S_IFG;
        end
      end
      S_IFG: begin
        cnt_nx = cnt + 16'd1;
        if (cnt_nx >= IFG_N) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      byte_cnt       <= '0;
      crc            <= '1;
      gmii_txd       <= '0;
      gmii_tx_en     <= 1'b0;
      gmii_tx_er     <= 1'b0;
      stat_frames    <= '0;
      stat_underruns <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      crc        <= crc_nx;
      gmii_txd   <= txd_nx;
      gmii_tx_en <= tx_en_nx;
      gmii_tx_er <= tx_er_nx;
      if (frame_inc && (stat_frames != '1))
        stat_frames <= stat_frames + 1'b1;
      if (underrun_inc && (stat_underruns != '1))
        stat_underruns <= stat_underruns + 1'b1;
    end
  end

endmodule

// File: tb/tb_egress_tx_framer.sv
// Directed bench for egress_tx_framer: one unpadded and one padded instance,
// frames captured from the wire and compared against bench-built reference frames.
module tb_egress_tx_framer;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic v, l;
  logic [7:0] d;

  logic v0, v1;
  logic rdy0, en0, er0, busy0, rdy1, en1, er1, busy1;
  logic [7:0] txd0, txd1;
  logic [31:0] fr0, un0, fr1, un1;

  logic rdy_s, en_s, er_s, busy_s;
  logic [7:0] txd_s;

  always #5 clk = ~clk;

  assign v0     = v && !sel;
  assign v1     = v && sel;
  assign rdy_s  = sel ? rdy1  : rdy0;
  assign en_s   = sel ? en1   : en0;
  assign er_s   = sel ? er1   : er0;
  assign busy_s = sel ? busy1 : busy0;
  assign txd_s  = sel ? txd1  : txd0;

  egress_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME(60), .PAD_EN(1'b0), .IFG_BYTES(12), .CNT_W(32)) u_nopad (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d), .in_last(l), .in_ready(rdy0),
    .gmii_tx_en(en0), .gmii_tx_er(er0), .gmii_txd(txd0),
    .stat_frames(fr0), .stat_underruns(un0), .busy(busy0));

  egress_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME(60), .PAD_EN(1'b1), .IFG_BYTES(12), .CNT_W(32)) u_pad (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d), .in_last(l), .in_ready(rdy1),
    .gmii_tx_en(en1), .gmii_tx_er(er1), .gmii_txd(txd1),
    .stat_frames(fr1), .stat_underruns(un1), .busy(busy1));

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] pay[$];
  logic [7:0] exp_q[$];
  logic [7:0] cap[$];
  int er_cnt = 0, er_no_en = 0, en_run = 0, last_run = 0;
  int zero_run = 0, last_gap = 0, ready_cnt = 0;
  logic prev_en = 1'b0;

  // Wire monitor on the selected instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rdy_s) ready_cnt++;
    if (er_s) begin
      er_cnt++;
      if (!en_s) er_no_en++;
    end
    if (en_s) begin
      if (!prev_en) begin
        last_gap = zero_run;
        en_run   = 0;
      end
      en_run++;
      cap.push_back(txd_s);
    end else begin
      if (prev_en) begin
        last_run = en_run;
        zero_run = 0;
      end
      zero_run++;
    end
    prev_en = en_s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[j])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[j][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  task automatic push_preamble();
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endtask

  task automatic build_exp(input bit pad);
    logic [7:0] body[$];
    logic [31:0] f;
    body = pay;
    if (pad) while (body.size() < 60) body.push_back(8'h00);
    f = ref_crc(body);
    push_preamble();
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
  endtask

  task automatic check_frame(input string tag);
    int mism = 0;
    chk({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, mism, 0);
  endtask

  task automatic send(input int stall_at);
    int t;
    for (int i = 0; i < pay.size(); i++) begin
      if (i == stall_at) begin
        v = 1'b0;
        @(negedge clk);
      end
      v = 1'b1;
      d = pay[i];
      l = (i == pay.size() - 1);
      t = 0;
      while (!rdy_s && t < 1000) begin
        @(negedge clk);
        t++;
      end
      n_chk++;
      assert (t < 1000) n_pass++;
      else $error("FAIL handshake_timeout observed=%0d expected=<1000", t);
      @(posedge clk);
      @(negedge clk);
    end
    v = 1'b0;
    l = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_s && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    assert (t < 2000) n_pass++;
    else $error("FAIL idle_timeout observed=%0d expected=<2000", t);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; v = 1'b0; l = 1'b0; d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", {31'b0, en1}, 0);
    chk("rst_txd", {24'b0, txd1}, 0);
    chk("rst_ready_busy", {30'b0, rdy1, busy1}, 0);
    chk("rst_counters", fr1 | un1 | fr0 | un0, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: no padding, "123456789"
    sel = 1'b0;
    cap.delete();
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_preamble();
    foreach (pay[i]) exp_q.push_back(pay[i]);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    send(-1);
    wait_idle();
    check_frame("t1_frame");
    chk("t1_en_cycles", last_run, 21);
    chk("t1_frames", fr0, 1);

    // 2: 14-byte packet padded to 60
    sel = 1'b1;
    cap.delete();
    pay.delete();
    for (int i = 1; i <= 14; i++) pay.push_back(8'(i));
    build_exp(1'b1);
    send(-1);
    wait_idle();
    check_frame("t2_frame");
    chk("t2_en_cycles", last_run, 72);
    chk("t2_frames", fr1, 1);

    // 3: two 64-byte packets back to back
    cap.delete();
    ready_cnt = 0;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i * 3 + 7));
    build_exp(1'b1);
    send(-1);
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(255 - i));
    begin
      logic [7:0] first[$];
      first = exp_q;
      build_exp(1'b1);
      exp_q = {first, exp_q};
    end
    send(-1);
    wait_idle();
    check_frame("t3_frames");
    chk("t3_gap", last_gap, 12);
    chk("t3_ready_cycles", ready_cnt, 128);
    chk("t3_frames", fr1, 3);

    // 4: underrun after byte 20
    cap.delete();
    er_cnt = 0;
    er_no_en = 0;
    pay.delete();
    for (int i = 0; i < 30; i++) pay.push_back(8'(8'hA0 + i));
    push_preamble();
    for (int i = 0; i < 20; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(8'h00);
    send(20);
    wait_idle();
    check_frame("t4_abort");
    chk("t4_er_cycles", er_cnt, 1);
    chk("t4_er_without_en", er_no_en, 0);
    chk("t4_underruns", un1, 1);
    chk("t4_frames_held", fr1, 3);
    cap.delete();
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    build_exp(1'b1);
    send(-1);
    wait_idle();
    check_frame("t4_clean");
    chk("t4_frames_after", fr1, 4);

    // 5: reset while the FCS is on the wire
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i ^ 8'h5A));
    build_exp(1'b1);
    send(-1);
    @(negedge clk);
    chk("t5_fcs0_on_wire", {23'b0, en1, txd1}, {23'b0, 1'b1, exp_q[72]});
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_outputs", {21'b0, en1, er1, txd1, rdy1, busy1}, 0);
    chk("t5_rst_counters", fr1 | un1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cap.delete();
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_exp(1'b1);
    send(-1);
    wait_idle();
    check_frame("t5_after_reset");
    chk("t5_frames", fr1, 1);

    // 6: single-byte packet
    cap.delete();
    pay = '{8'hC3};
    build_exp(1'b1);
    send(-1);
    wait_idle();
    check_frame("t6_frame");
    chk("t6_en_cycles", last_run, 72);
    chk("t6_frames", fr1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
